// File: rtl/power_seq_ctrl.sv
// Power-stage sequencer: precharge -> main contactor -> run, with timed shutdown,
// filtered fault/stop inputs, latched fault code and fan run-on after power-down.
module power_seq_ctrl #(
  parameter int TW       = 28,
  parameter int T_PRE    = 25000000,
  parameter int T_SETTLE = 5000000,
  parameter int T_DISCH  = 5000000,
  parameter int T_FAN    = 250000000,
  parameter int ERR_FILT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_req,
  input  logic       stop_req,
  input  logic       fault_clr,
  input  logic       stop_k,
  input  logic [5:0] err_in,
  output logic       charge_en,
  output logic       main_en,
  output logic       gate_en,
  output logic       fan_en,
  output logic       ready,
  output logic       fault,
  output logic [5:0] fault_code,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRECHARGE = 3'd1,
    S_MAIN_ON   = 3'd2,
    S_RUN       = 3'd3,
    S_SHUTDOWN  = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  localparam int NCH = 7;
  localparam int CW  = $clog2(ERR_FILT + 1);
  localparam logic [CW-1:0] FILT_C = CW'(ERR_FILT);
  localparam longint TMAX = longint'(1) << TW;

  localparam logic [TW-1:0] LD_PRE    = TW'(T_PRE - 1);
  localparam logic [TW-1:0] LD_SETTLE = TW'(T_SETTLE - 1);
  localparam logic [TW-1:0] LD_DISCH  = TW'(T_DISCH - 1);
  localparam logic [TW-1:0] LD_FAN    = (T_FAN == 0) ? '0 : TW'(T_FAN - 1);
  localparam logic          FAN_ON    = (T_FAN != 0);

  if (T_PRE < 1 || longint'(T_PRE) >= TMAX) begin : g_bad_pre
    $error("T_PRE must be in 1 .. 2**TW-1");
  end
  if (T_SETTLE < 1 || longint'(T_SETTLE) >= TMAX) begin : g_bad_settle
    $error("T_SETTLE must be in 1 .. 2**TW-1");
  end
  if (T_DISCH < 1 || longint'(T_DISCH) >= TMAX) begin : g_bad_disch
    $error("T_DISCH must be in 1 .. 2**TW-1");
  end
  if (T_FAN < 0 || longint'(T_FAN) >= TMAX) begin : g_bad_fan
    $error("T_FAN must be in 0 .. 2**TW-1");
  end
  if (ERR_FILT < 1) begin : g_bad_filt
    $error("ERR_FILT must be at least 1");
  end

  // Input conditioning: 2-FF synchroniser then saturating run-length counter
  logic [NCH-1:0] raw, sync_p0, sync_p1, filt;
  logic [CW-1:0]  cnt [NCH];

  assign raw = {stop_k, err_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      for (int i = 0; i < NCH; i++) begin
        if (!sync_p1[i])          cnt[i] <= '0;
        else if (cnt[i] != FILT_C) cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

  // Gating with the synchronised level drops the filtered bit as soon as the line clears
  always_comb begin
    filt = '0;
    for (int i = 0; i < NCH; i++) filt[i] = sync_p1[i] && (cnt[i] == FILT_C);
  end

  logic [5:0] err_bits;
  logic       err_f, stop_f, stop_any;

  assign err_bits = filt[5:0];
  assign err_f    = |err_bits;
  assign stop_f   = filt[6];
  assign stop_any = stop_req || stop_f;

  // Sequencer state, timers and registered outputs
  state_t        state_q, state_n;
  logic [TW-1:0] tmr_q, tmr_n, fan_tmr_q, fan_tmr_n;
  logic [5:0]    code_n;
  logic          fan_load;
  logic          charge_n, main_n, gate_n, fan_n, ready_n, fault_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      fan_tmr_q  <= '0;
      fault_code <= '0;
      charge_en  <= 1'b0;
      main_en    <= 1'b0;
      gate_en    <= 1'b0;
      fan_en     <= 1'b0;
      ready      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state_q    <= state_n;
      tmr_q      <= tmr_n;
      fan_tmr_q  <= fan_tmr_n;
      fault_code <= code_n;
      charge_en  <= charge_n;
      main_en    <= main_n;
      gate_en    <= gate_n;
      fan_en     <= fan_n;
      ready      <= ready_n;
      fault      <= fault_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    tmr_n    = (tmr_q != '0) ? tmr_q - 1'b1 : '0;
    code_n   = fault_code;
    fan_load = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (err_f) begin
          state_n = S_FAULT;
          code_n  = err_bits;
        end else if (start_req && !stop_f) begin
          state_n = S_PRECHARGE;
          tmr_n   = LD_PRE;
        end
      end
      S_PRECHARGE: begin
        if (err_f) begin
          state_n = S_FAULT;
          code_n  = err_bits;
        end else if (stop_any) begin
          state_n = S_SHUTDOWN;
          tmr_n   = LD_DISCH;
        end else if (tmr_q == '0) begin
          state_n = S_MAIN_ON;
          tmr_n   = LD_SETTLE;
        end
      end
      S_MAIN_ON: begin
        if (err_f) begin
          state_n = S_FAULT;
          code_n  = err_bits;
        end else if (stop_any) begin
          state_n = S_SHUTDOWN;
          tmr_n   = LD_DISCH;
        end else if (tmr_q == '0) begin
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (err_f) begin
          state_n = S_FAULT;
          code_n  = err_bits;
        end else if (stop_any) begin
          state_n = S_SHUTDOWN;
          tmr_n   = LD_DISCH;
        end
      end
      S_SHUTDOWN: begin
        if (err_f) begin
          state_n = S_FAULT;
          code_n  = err_bits;
        end else if (tmr_q == '0) begin
          state_n  = S_IDLE;
          fan_load = 1'b1;
        end
      end
      S_FAULT: begin
        code_n = fault_code | err_bits;
        if (fault_clr && !err_f) begin
          state_n  = S_IDLE;
          code_n   = '0;
          fan_load = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Run-on only counts while resting in IDLE; any other state abandons it
    if (fan_load)                                   fan_tmr_n = LD_FAN;
    else if (state_n == S_IDLE && fan_tmr_q != '0)  fan_tmr_n = fan_tmr_q - 1'b1;
    else                                            fan_tmr_n = '0;

    charge_n = 1'b0;
    main_n   = 1'b0;
    gate_n   = 1'b0;
    fan_n    = 1'b0;
    ready_n  = 1'b0;
    fault_n  = 1'b0;
    unique case (state_n)
      S_IDLE:      fan_n = fan_load ? FAN_ON : (fan_tmr_q != '0);
      S_PRECHARGE: begin charge_n = 1'b1; fan_n = 1'b1; end
      S_MAIN_ON:   begin charge_n = 1'b1; main_n = 1'b1; fan_n = 1'b1; end
      S_RUN:       begin main_n = 1'b1; gate_n = 1'b1; fan_n = 1'b1; ready_n = 1'b1; end
      S_SHUTDOWN:  fan_n = 1'b1;
      S_FAULT:     begin fan_n = 1'b1; fault_n = 1'b1; end
      default:     fan_n = 1'b0;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_power_seq_ctrl.sv
// Directed bench for power_seq_ctrl with short timing parameters.
module tb_power_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start_req, stop_req, fault_clr, stop_k;
  logic [5:0] err_in;
  logic       charge_en, main_en, gate_en, fan_en, ready, fault;
  logic [5:0] fault_code;
  logic [2:0] state;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  power_seq_ctrl #(
    .TW(12), .T_PRE(10), .T_SETTLE(5), .T_DISCH(8), .T_FAN(20), .ERR_FILT(4)
  ) dut (
    .clk(clk), .rst(rst), .start_req(start_req), .stop_req(stop_req),
    .fault_clr(fault_clr), .stop_k(stop_k), .err_in(err_in),
    .charge_en(charge_en), .main_en(main_en), .gate_en(gate_en), .fan_en(fan_en),
    .ready(ready), .fault(fault), .fault_code(fault_code), .state(state)
  );

  always #5 clk = ~clk;

  // {charge_en, main_en, gate_en, fan_en, ready, fault, state}
  logic [8:0] obs;
  assign obs = {charge_en, main_en, gate_en, fan_en, ready, fault, state};

  localparam logic [8:0] V_IDLE     = {6'b000000, 3'd0};
  localparam logic [8:0] V_IDLE_FAN = {6'b000100, 3'd0};
  localparam logic [8:0] V_PRE      = {6'b100100, 3'd1};
  localparam logic [8:0] V_MAIN     = {6'b110100, 3'd2};
  localparam logic [8:0] V_RUN      = {6'b011110, 3'd3};
  localparam logic [8:0] V_SHUT     = {6'b000100, 3'd4};
  localparam logic [8:0] V_FLT      = {6'b000101, 3'd5};

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_req = 0; stop_req = 0; fault_clr = 0; stop_k = 0; err_in = '0;
    tick(2);
    chk_cnt++;
    if (obs !== V_IDLE) $display("FAIL reset_outs: got %b exp %b", obs, V_IDLE);
    else pass_cnt++;
    rst = 1'b0;
    tick(1);
    chk_cnt++;
    if ({obs, fault_code} !== {V_IDLE, 6'b0}) $display("FAIL reset_release: got %b exp %b", {obs, fault_code}, {V_IDLE, 6'b0});
    else pass_cnt++;
  endtask

  task automatic test_start_seq();
    start_req = 1'b1;
    tick(1);
    start_req = 1'b0;
    chk_cnt++;
    if (obs !== V_PRE) $display("FAIL seq_edge0: got %b exp %b", obs, V_PRE);
    else pass_cnt++;
    tick(9);
    chk_cnt++;
    if (obs !== V_PRE) $display("FAIL seq_edge9: got %b exp %b", obs, V_PRE);
    else pass_cnt++;
    tick(1);
    chk_cnt++;
    if (obs !== V_MAIN) $display("FAIL seq_edge10: got %b exp %b", obs, V_MAIN);
    else pass_cnt++;
    tick(4);
    chk_cnt++;
    if (obs !== V_MAIN) $display("FAIL seq_edge14: got %b exp %b", obs, V_MAIN);
    else pass_cnt++;
    tick(1);
    chk_cnt++;
    if (obs !== V_RUN) $display("FAIL seq_edge15: got %b exp %b", obs, V_RUN);
    else pass_cnt++;
  endtask

  task automatic test_stop();
    stop_req = 1'b1;
    tick(1);
    stop_req = 1'b0;
    chk_cnt++;
    if (obs !== V_SHUT) $display("FAIL stop_e: got %b exp %b", obs, V_SHUT);
    else pass_cnt++;
    tick(7);
    chk_cnt++;
    if (obs !== V_SHUT) $display("FAIL stop_e7: got %b exp %b", obs, V_SHUT);
    else pass_cnt++;
    tick(1);
    chk_cnt++;
    if (obs !== V_IDLE_FAN) $display("FAIL stop_e8: got %b exp %b", obs, V_IDLE_FAN);
    else pass_cnt++;
    tick(19);
    chk_cnt++;
    if (obs !== V_IDLE_FAN) $display("FAIL fan_e27: got %b exp %b", obs, V_IDLE_FAN);
    else pass_cnt++;
    tick(1);
    chk_cnt++;
    if (obs !== V_IDLE) $display("FAIL fan_e28: got %b exp %b", obs, V_IDLE);
    else pass_cnt++;
  endtask

  task automatic test_err_filter();
    err_in = 6'b000100;
    tick(3);
    err_in = '0;
    tick(8);
    chk_cnt++;
    if ({obs, fault_code} !== {V_IDLE, 6'b0}) $display("FAIL glitch3: got %b exp %b", {obs, fault_code}, {V_IDLE, 6'b0});
    else pass_cnt++;
    err_in = 6'b000100;
    tick(6);
    chk_cnt++;
    if (obs !== V_IDLE) $display("FAIL err_k5: got %b exp %b", obs, V_IDLE);
    else pass_cnt++;
    tick(1);
    chk_cnt++;
    if ({obs, fault_code} !== {V_FLT, 6'b000100}) $display("FAIL err_k6: got %b exp %b", {obs, fault_code}, {V_FLT, 6'b000100});
    else pass_cnt++;
  endtask

  task automatic test_fault_clr();
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    chk_cnt++;
    if ({obs, fault_code} !== {V_FLT, 6'b000100}) $display("FAIL clr_blocked: got %b exp %b", {obs, fault_code}, {V_FLT, 6'b000100});
    else pass_cnt++;
    err_in = 6'b000101;
    tick(7);
    chk_cnt++;
    if ({obs, fault_code} !== {V_FLT, 6'b000101}) $display("FAIL code_sticky: got %b exp %b", {obs, fault_code}, {V_FLT, 6'b000101});
    else pass_cnt++;
    err_in = '0;
    tick(3);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    chk_cnt++;
    if ({obs, fault_code} !== {V_IDLE_FAN, 6'b0}) $display("FAIL clr_ok: got %b exp %b", {obs, fault_code}, {V_IDLE_FAN, 6'b0});
    else pass_cnt++;
    tick(19);
    chk_cnt++;
    if (obs !== V_IDLE_FAN) $display("FAIL clr_fan19: got %b exp %b", obs, V_IDLE_FAN);
    else pass_cnt++;
    tick(1);
    chk_cnt++;
    if (obs !== V_IDLE) $display("FAIL clr_fan20: got %b exp %b", obs, V_IDLE);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    start_req = 1'b1;
    err_in    = 6'b000010;
    tick(1);
    start_req = 1'b0;
    tick(5);
    chk_cnt++;
    if (obs !== V_PRE) $display("FAIL prio_pre: got %b exp %b", obs, V_PRE);
    else pass_cnt++;
    stop_req = 1'b1;
    tick(1);
    stop_req = 1'b0;
    chk_cnt++;
    if ({obs, fault_code} !== {V_FLT, 6'b000010}) $display("FAIL prio_err_stop: got %b exp %b", {obs, fault_code}, {V_FLT, 6'b000010});
    else pass_cnt++;
    err_in = '0;
    tick(3);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    chk_cnt++;
    if (state !== 3'd0) $display("FAIL prio_clr: got %0d exp %0d", state, 0);
    else pass_cnt++;
    stop_k = 1'b1;
    tick(7);
    start_req = 1'b1;
    tick(1);
    start_req = 1'b0;
    chk_cnt++;
    if ({state, charge_en} !== {3'd0, 1'b0}) $display("FAIL stopk_blocks_start: got %b exp %b", {state, charge_en}, {3'd0, 1'b0});
    else pass_cnt++;
    stop_k = 1'b0;
    tick(25);
  endtask

  task automatic test_async_reset();
    test_start_seq();
    #3 rst = 1'b1;
    #1;
    chk_cnt++;
    if ({obs, fault_code} !== {V_IDLE, 6'b0}) $display("FAIL async_rst: got %b exp %b", {obs, fault_code}, {V_IDLE, 6'b0});
    else pass_cnt++;
    tick(2);
    rst = 1'b0;
    tick(1);
    test_start_seq();
  endtask

  initial begin
    test_reset();
    test_start_seq();
    test_stop();
    test_err_filter();
    test_fault_clr();
    test_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/power_seq_ctrl.md
Name: power_seq_ctrl

Overview:
Power-stage sequencer for the converter board. Drives precharge relay (O_CHARGE), main contactor (O_CH), bridge gate-driver enable and fan (O_FAN) through a fixed start/stop sequence. Latches faults from the I_ERR_* lines and responds to the stop key (I_STOP_K). Receives single-cycle start/stop/clear commands from the UART command decoder in the top level.

Parameters:
TW, 28, width of the phase timer and the fan timer.
T_PRE, 25000000, precharge duration in clk cycles (0.5 s at 50 MHz); must be ≥1.
T_SETTLE, 5000000, main-contactor settle time before gates are enabled; must be ≥1.
T_DISCH, 5000000, shutdown hold time before returning to IDLE; must be ≥1.
T_FAN, 250000000, fan run-on after SHUTDOWN or FAULT exits to IDLE.
ERR_FILT, 4, consecutive synchronised-high cycles needed before an error or stop input is accepted.

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-high reset
start_req  in  1  synchronous single-cycle start command
stop_req  in  1  synchronous single-cycle stop command
fault_clr  in  1  synchronous single-cycle fault-clear command
stop_k  in  1  asynchronous stop key, 1 = stop pressed
err_in  in  6  asynchronous error lines {ERR_DR_4, ERR_DR_3, ERR_DR_2, ERR_DR_1, ERR_I, ERR_U}, 1 = error
charge_en  out  1  precharge relay
main_en  out  1  main contactor
gate_en  out  1  bridge gate-driver enable
fan_en  out  1  fan
ready  out  1  1 in RUN only
fault  out  1  1 in FAULT only
fault_code  out  6  sticky OR of filtered err_in captured while in FAULT
state  out  3  IDLE=0, PRECHARGE=1, MAIN_ON=2, RUN=3, SHUTDOWN=4, FAULT=5

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs, timers, synchroniser and filter flops = 0. Outputs drop immediately with no clock edge, including during RUN.
- Input conditioning for each err_in bit and stop_k:
  - 2-FF synchroniser, then a saturating counter.
  - Counter increments while the synchronised value is 1 and clears to 0 when it is 0.
  - Filtered bit = (counter == ERR_FILT). It deasserts on the first cycle the synchronised value is 0.
  - err_f = OR of the filtered err bits. stop_f = filtered stop_k.
  - Latency: an input first sampled high at edge k produces filtered=1 after edge k+1+ERR_FILT. The FSM reacts at edge k+2+ERR_FILT.
- Outputs are registered and updated on the same edge as state:
  - IDLE: fan_en = (fan timer ≠ 0); all other outputs 0.
  - PRECHARGE: charge_en=1, fan_en=1.
  - MAIN_ON: charge_en=1, main_en=1, fan_en=1.
  - RUN: main_en=1, gate_en=1, fan_en=1, ready=1.
  - SHUTDOWN: fan_en=1 only.
  - FAULT: fan_en=1, fault=1.
- Phase timer: on entry to a timed state it loads T−1 and decrements each cycle. The exit transition fires on the edge where the timer is 0, so each timed state lasts exactly T cycles.
- Transition priority per cycle: err_f > stop (stop_req or stop_f) > start_req > timer expiry.
  - Any state except FAULT, err_f=1: go to FAULT; fault_code <= filtered err bits.
  - PRECHARGE, MAIN_ON or RUN, stop: go to SHUTDOWN (T_DISCH).
  - IDLE, start_req && !stop_f: go to PRECHARGE (T_PRE). start_req is ignored in every other state and while stop_f=1.
  - PRECHARGE expiry: MAIN_ON (T_SETTLE). MAIN_ON expiry: RUN. SHUTDOWN expiry: IDLE.
  - FAULT: fault_code |= filtered err bits every cycle. fault_clr && !err_f: go to IDLE and clear fault_code. fault_clr with err_f=1 is ignored.
  - stop_req in IDLE or FAULT is ignored. fault_clr outside FAULT is ignored.
- Fan timer:
  - Loads T_FAN−1 on entry to IDLE from SHUTDOWN or FAULT. It is not loaded after reset.
  - Decrements in IDLE until 0; fan_en drops the cycle after it reaches 0, giving T_FAN cycles of fan on.
  - Leaving IDLE abandons the run-on; fan_en=1 from the new state's decode.
- Timers are TW bits wide. Every T parameter must be < 2^TW; this is checked by an elaboration assertion.

Test Plan:
1. T_PRE=10, T_SETTLE=5; start_req at edge 0 -> charge_en=1 after edge 0; main_en=1 after edge 10; RUN after edge 15 with gate_en=ready=1 and charge_en=0.
2. In RUN, stop_req at edge e (T_DISCH=8, T_FAN=20) -> after e: state=4, gate_en=main_en=0, fan_en=1; IDLE after e+8; fan_en=0 after e+28.
3. ERR_FILT=4; err_in[2] high for 3 sample cycles -> no fault. Held high from sample edge k -> FAULT after edge k+6 with fault_code=6'b000100 and all power outputs 0.
4. In FAULT with err_in[2] still high, fault_clr -> stays FAULT. err_in[2] low, wait 3 cycles, fault_clr -> IDLE, fault_code=0, fan run-on T_FAN.
5. In PRECHARGE, filtered error and stop_req on the same edge -> FAULT (not SHUTDOWN). stop_k held high in IDLE plus start_req -> remains IDLE.
6. Assert rst mid-RUN between clock edges -> all outputs 0 before the next edge. Release rst, then start_req -> full sequence repeats as in scenario 1.
